lcd_char_writer: RTL and testbench
==================================

# lcd_char_writer

Downstream stage of the game controller: accepts one character byte per `ReadPulse` request, drives it onto a HD44780-compatible character LCD in 8-bit write-only mode, and returns `read_done` when the byte has been written. Runs the LCD power-up initialisation sequence autonomously after reset. All LCD bus timing is generated by cycle counters derived from parameters.

## Interface
- `E_CYC`, default 25, E-high width and initial setup width, in clock cycles (≥1)
- `CMD_WAIT_CYC`, default 2000, post-strobe wait for ordinary commands and data (≥40 µs at 50 MHz)
- `CLR_WAIT_CYC`, default 82000, post-strobe wait after clear display (≥1.64 ms)
- `PWRUP_CYC`, default 750000, wait before the first init command (≥15 ms)
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous and active-high.
- `LCD_data`  in  8  character code; sampled in the cycle a request is accepted.
- `ReadPulse`  in  1  request level from the controller; held high until `read_done` is seen.
- `read_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `lcd_rs`  out  1  0 = command, 1 = data.
- `lcd_rw`  out  1  tied 0 (write only).
- `lcd_e`  out  1  enable strobe.
- `lcd_db`  out  8  LCD data bus.

## Operation
- Reset values: `read_done`=0, `busy`=1, `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `lcd_db`=8'h00; state=PWR_WAIT; counters=0.
- States: PWR_WAIT, INIT (index 0–5), IDLE, [CLEAR], SET_ADDR, WR_CHAR, DONE, WAIT_LOW.
- PWR_WAIT: counts `PWRUP_CYC` cycles, then goes to INIT index 0.
- INIT: sends the commands 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06 in that order, all with rs=0. Index 4 (clear) uses `CLR_WAIT_CYC`; the others use `CMD_WAIT_CYC`. After index 5 the state moves to IDLE.
- IDLE: if `ReadPulse`=1, latch `LCD_data` into `char_q` and go to CLEAR (macro on) or SET_ADDR (macro off). `ReadPulse` asserted during PWR_WAIT/INIT is not lost; because it is a level, it is accepted on the first IDLE cycle.
- SET_ADDR: command 8'h80 (DDRAM address 0, line 1 column 0), then WR_CHAR.
- WR_CHAR: data transfer of `char_q` with rs=1, then DONE.
- DONE: `read_done`=1 for exactly one cycle, then WAIT_LOW.
- WAIT_LOW: stays until `ReadPulse`=0, then goes to IDLE. This prevents a retrigger, because the controller drops `ReadPulse` one cycle after it sees `read_done`.
- Byte transfer, identical for commands and data:
  - 1 cycle with E=0 and `lcd_rs`/`lcd_db` valid;
  - then `E_CYC` cycles with E=1;
  - then the wait count with E=0, with `lcd_db` and `lcd_rs` held.
  - Total length is 1 + `E_CYC` + wait cycles.
- Counter width: 20 bits. Wait counts that exceed 2^20−1 are a parameter error.
- `rst` mid-operation: abort immediately, outputs take reset values, and the full power-up sequence re-runs. A pending request is served only after re-initialisation, and only if `ReadPulse` is still high.

## Timing
- Init duration: `PWRUP_CYC` + 6·(1+`E_CYC`) + 5·`CMD_WAIT_CYC` + `CLR_WAIT_CYC` cycles.
- Request latency, macro off: accept cycle → `read_done` high = 2·(1+`E_CYC`+`CMD_WAIT_CYC`) + 1 cycles.
- Request latency, macro on: add 1+`E_CYC`+`CLR_WAIT_CYC`.
- `read_done` is never asserted in two consecutive cycles.
- No new request is accepted until at least 1 cycle after `ReadPulse` has been observed low.
- `LCD_data` changes after acceptance have no effect on the byte written.

## Configuration
- `LCD_CLEAR_ON_WRITE_EN`
  - Defined: each request first issues clear (8'h01, `CLR_WAIT_CYC`) in state CLEAR, so only the new character is visible.
  - Undefined: the CLEAR state is absent and the character overwrites position 0 directly.

## Structure
- Package `lcd_pkg` holds:
  - command constants: `LCD_FUNC_SET`=8'h38, `LCD_DISP_ON`=8'h0C, `LCD_CLEAR`=8'h01, `LCD_ENTRY`=8'h06, `LCD_HOME_ADDR`=8'h80;
  - the state enum;
  - the init-command ROM function (index → byte, wait select).
- Sub-module `lcd_strobe`: the byte-transfer engine. It takes a start pulse, rs, byte and wait-count; it produces E/RS/DB and a `xfer_done` pulse. The top-level FSM only sequences transfers.

## Test plan
Run with reduced parameters: `E_CYC`=2, `CMD_WAIT_CYC`=5, `CLR_WAIT_CYC`=20, `PWRUP_CYC`=50.
- Reset, no request → exactly 6 E pulses carrying 38, 38, 38, 0C, 01, 06 with rs=0; `busy` falls at cycle 50+18+25+20. Check the E-high width of 2 cycles.
- Request with `LCD_data`=8'h41 after init, macro off:
  - E pulses 80 (rs=0), then 41 (rs=1);
  - `read_done` high for 1 cycle, 17 cycles after acceptance.
- `ReadPulse` held high 1 cycle past `read_done` → no second write; next request after low accepted normally.
- `ReadPulse`=1 from reset with 8'h5A → held off until IDLE, then 5A written; no write occurs during init.
- `rst` pulsed during WR_CHAR → `lcd_e`=0 next cycle, `read_done` never pulses, init sequence repeats from PWR_WAIT.
- `LCD_CLEAR_ON_WRITE_EN` defined, `LCD_data`=8'h33 → bytes 01, 80, 33; latency 17+23=40 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character writer: command codes,
// FSM state encodings and the power-up init command table.
// Optional feature macro: LCD_CLEAR_ON_WRITE_EN (adds the CLEAR state).
package lcd_pkg;

    localparam int unsigned CNT_W = 20;

    localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_HOME_ADDR = 8'h80;

    localparam logic [2:0] INIT_LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
`ifdef LCD_CLEAR_ON_WRITE_EN
        ST_CLEAR,
`endif
        ST_SET_ADDR,
        ST_WR_CHAR,
        ST_DONE,
        ST_WAIT_LOW
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_HIGH,
        PH_WAIT
    } strobe_phase_e;

    typedef struct packed {
        logic [7:0] code;
        logic       long_wait;   // 1 selects the clear-display wait count
    } init_cmd_t;

    function automatic init_cmd_t init_rom(input logic [2:0] idx);
        init_cmd_t c;
        c.long_wait = 1'b0;
        case (idx)
            3'd0, 3'd1, 3'd2: c.code = LCD_FUNC_SET;
            3'd3:             c.code = LCD_DISP_ON;
            3'd4: begin
                c.code      = LCD_CLEAR;
                c.long_wait = 1'b1;
            end
            default:          c.code = LCD_ENTRY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_char_writer_strobe.sv
// Byte-transfer engine: one setup cycle with E low, E_CYC cycles with E
// high, then the requested wait with E low. RS/DB hold their last value.
module lcd_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned E_CYC = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             rs_i,
    input  logic [7:0]       byte_i,
    input  logic [CNT_W-1:0] wait_i,
    output logic             lcd_e_o,
    output logic             lcd_rs_o,
    output logic [7:0]       lcd_db_o,
    output logic             xfer_done_o
);

    localparam logic [CNT_W-1:0] E_LAST = CNT_W'(E_CYC - 1);

    strobe_phase_e    phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_q;
    logic             rs_q;
    logic [7:0]       db_q;

    // Phase/counter registers; bus values latched when a transfer starts
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            rs_q    <= 1'b0;
            db_q    <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            if (start_i) begin
                wait_q <= wait_i;
                rs_q   <= rs_i;
                db_q   <= byte_i;
            end
        end
    end

    // Next phase: setup -> E high -> wait -> idle
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_HIGH;
                    cnt_d   = '0;
                end
                PH_HIGH: begin
                    if (cnt_q == E_LAST) begin
                        cnt_d   = '0;
                        phase_d = (wait_q == '0) ? PH_IDLE : PH_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_WAIT: begin
                    if (cnt_q == wait_q - CNT_W'(1)) begin
                        phase_d = PH_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs and done pulse in the final cycle of the transfer
    always_comb begin
        lcd_e_o     = (phase_q == PH_HIGH);
        lcd_rs_o    = rs_q;
        lcd_db_o    = db_q;
        xfer_done_o = ((phase_q == PH_WAIT) && (cnt_q == wait_q - CNT_W'(1))) ||
                      ((phase_q == PH_HIGH) && (cnt_q == E_LAST) && (wait_q == '0));
    end

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 character writer: autonomous power-up init, then one character
// written to DDRAM address 0 per ReadPulse request, acknowledged by read_done.
// Optional feature macro: LCD_CLEAR_ON_WRITE_EN (clear display before each write).
module lcd_char_writer
    import lcd_pkg::*;
#(
    parameter int unsigned E_CYC        = 25,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000,
    parameter int unsigned PWRUP_CYC    = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] LCD_data,
    input  logic       ReadPulse,
    output logic       read_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam logic [CNT_W-1:0] CMD_W    = CNT_W'(CMD_WAIT_CYC);
    localparam logic [CNT_W-1:0] CLR_W    = CNT_W'(CLR_WAIT_CYC);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_CYC - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       char_q, char_d;

    logic             xfer_start, xfer_rs, xfer_long, xfer_done;
    logic [7:0]       xfer_byte;
    init_cmd_t        init_cmd;

    // State, power-up counter, init index and latched character
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PWR_WAIT;
            pwr_cnt_q <= '0;
            idx_q     <= '0;
            char_q    <= '0;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            idx_q     <= idx_d;
            char_q    <= char_d;
        end
    end

    // Next-state sequencing; transfer states advance on xfer_done
    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        idx_d     = idx_q;
        char_d    = char_q;
        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + CNT_W'(1);
                end
            end
            ST_INIT: begin
                if (xfer_done) begin
                    if (idx_q == INIT_LAST_IDX) state_d = ST_IDLE;
                    else                        idx_d   = idx_q + 3'd1;
                end
            end
            ST_IDLE: begin
                if (ReadPulse) begin
                    char_d = LCD_data;
`ifdef LCD_CLEAR_ON_WRITE_EN
                    state_d = ST_CLEAR;
`else
                    state_d = ST_SET_ADDR;
`endif
                end
            end
`ifdef LCD_CLEAR_ON_WRITE_EN
            ST_CLEAR:    if (xfer_done) state_d = ST_SET_ADDR;
`endif
            ST_SET_ADDR: if (xfer_done) state_d = ST_WR_CHAR;
            ST_WR_CHAR:  if (xfer_done) state_d = ST_DONE;
            ST_DONE:     state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!ReadPulse) state_d = ST_IDLE;
            default:     state_d = ST_PWR_WAIT;
        endcase
    end

    // Transfer launches are issued on the transition into the state that
    // owns the transfer, so back-to-back transfers have no idle gap.
    always_comb begin
        xfer_start = 1'b0;
        xfer_rs    = 1'b0;
        xfer_byte  = '0;
        xfer_long  = 1'b0;
        init_cmd   = init_rom(3'd0);
        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    xfer_start = 1'b1;
                    xfer_byte  = init_cmd.code;
                    xfer_long  = init_cmd.long_wait;
                end
            end
            ST_INIT: begin
                init_cmd = init_rom(idx_q + 3'd1);
                if (xfer_done && (idx_q != INIT_LAST_IDX)) begin
                    xfer_start = 1'b1;
                    xfer_byte  = init_cmd.code;
                    xfer_long  = init_cmd.long_wait;
                end
            end
            ST_IDLE: begin
                if (ReadPulse) begin
                    xfer_start = 1'b1;
`ifdef LCD_CLEAR_ON_WRITE_EN
                    xfer_byte  = LCD_CLEAR;
                    xfer_long  = 1'b1;
`else
                    xfer_byte  = LCD_HOME_ADDR;
`endif
                end
            end
`ifdef LCD_CLEAR_ON_WRITE_EN
            ST_CLEAR: begin
                if (xfer_done) begin
                    xfer_start = 1'b1;
                    xfer_byte  = LCD_HOME_ADDR;
                end
            end
`endif
            ST_SET_ADDR: begin
                if (xfer_done) begin
                    xfer_start = 1'b1;
                    xfer_rs    = 1'b1;
                    xfer_byte  = char_q;
                end
            end
            default: ;
        endcase
        read_done = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        lcd_rw    = 1'b0;
    end

    lcd_strobe #(
        .E_CYC(E_CYC)
    ) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .start_i    (xfer_start),
        .rs_i       (xfer_rs),
        .byte_i     (xfer_byte),
        .wait_i     (xfer_long ? CLR_W : CMD_W),
        .lcd_e_o    (lcd_e),
        .lcd_rs_o   (lcd_rs),
        .lcd_db_o   (lcd_db),
        .xfer_done_o(xfer_done)
    );

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer with reduced timing parameters. A negedge
// monitor logs every E pulse (rs, byte, high width) and read_done pulses;
// expectations come from the command lists and cycle formulas directly.
module tb_lcd_char_writer;

    localparam int E   = 2;
    localparam int CMD = 5;
    localparam int CLR = 20;
    localparam int PWR = 50;
`ifdef LCD_CLEAR_ON_WRITE_EN
    localparam bit CLR_ON = 1'b1;
`else
    localparam bit CLR_ON = 1'b0;
`endif
    localparam int INIT_CYC = PWR + 6 * (1 + E) + 5 * CMD + CLR;
    localparam int REQ_LAT  = 2 * (1 + E + CMD) + 1 + (CLR_ON ? (1 + E + CLR) : 0);

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] LCD_data;
    logic       ReadPulse;
    logic       read_done, busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;

    lcd_char_writer #(
        .E_CYC       (E),
        .CMD_WAIT_CYC(CMD),
        .CLR_WAIT_CYC(CLR),
        .PWRUP_CYC   (PWR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .LCD_data (LCD_data),
        .ReadPulse(ReadPulse),
        .read_done(read_done),
        .busy     (busy),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_db   (lcd_db)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] wr_q[$];
    int         width_q[$];
    int         rd_cnt = 0;
    int         rd_consec = 0;
    logic       e_prev = 1'b0;
    logic       rd_prev = 1'b0;
    int         hi_cnt = 0;

    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            wr_q.push_back({lcd_rs, lcd_db});
            hi_cnt = 1;
        end else if (lcd_e) begin
            hi_cnt++;
        end
        if (!lcd_e && e_prev) width_q.push_back(hi_cnt);
        if (read_done) begin
            rd_cnt++;
            if (rd_prev) rd_consec++;
        end
        rd_prev = read_done;
        e_prev  = lcd_e;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        width_q.delete();
        rd_cnt = 0;
        rd_consec = 0;
    endtask

    task automatic check_writes(input string tag, input logic [8:0] exp[$]);
        chk({tag, "_count"}, wr_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < wr_q.size()) chk($sformatf("%s[%0d]", tag, i), wr_q[i], exp[i]);
    endtask

    task automatic check_widths(input string tag);
        for (int i = 0; i < width_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), width_q[i], E);
    endtask

    // Bounded wait for busy low; returns negedges counted from cycle 0
    task automatic wait_idle(output int n, input int limit);
        n = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b0) break;
            n++;
            if (n > limit) break;
        end
    endtask

    function automatic void add_init(ref logic [8:0] q[$]);
        q.push_back({1'b0, 8'h38});
        q.push_back({1'b0, 8'h38});
        q.push_back({1'b0, 8'h38});
        q.push_back({1'b0, 8'h0C});
        q.push_back({1'b0, 8'h01});
        q.push_back({1'b0, 8'h06});
    endfunction

    function automatic void add_req(ref logic [8:0] q[$], input logic [7:0] ch);
        if (CLR_ON) q.push_back({1'b0, 8'h01});
        q.push_back({1'b0, 8'h80});
        q.push_back({1'b1, ch});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         hold;
        logic [7:0] d;
        logic [8:0] exp[$];
        bit         found;

        rst = 1'b1;
        ReadPulse = 1'b0;
        LCD_data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_done", read_done, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_db", lcd_db, 8'h00);

        // Power-up init sequence
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        wait_idle(n, 3000);
        chk("init_len", n, INIT_CYC);
        #1;
        exp.delete();
        add_init(exp);
        check_writes("init_wr", exp);
        check_widths("init_ehigh");
        chk("init_rd", rd_cnt, 0);

        // Random requests; data bus scrambled after acceptance
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
            d = (r == 0) ? 8'h41 : 8'($urandom_range(0, 255));
            clear_mon();
            LCD_data = d;
            ReadPulse = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (read_done === 1'b1) break;
                n++;
                if (n == 2) LCD_data = 8'($urandom_range(0, 255));
                if (n > 500) break;
            end
            chk($sformatf("req%0d_lat", r), n, REQ_LAT);
            hold = $urandom_range(1, 3);
            @(negedge clk);
            chk($sformatf("req%0d_rd_1cyc", r), read_done, 1'b0);
            repeat (hold - 1) @(negedge clk);
            ReadPulse = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("req%0d_idle", r), busy, 1'b0);
            chk($sformatf("req%0d_rd_cnt", r), rd_cnt, 1);
            chk($sformatf("req%0d_rd_consec", r), rd_consec, 0);
            exp.delete();
            add_req(exp, d);
            check_writes($sformatf("req%0d_wr", r), exp);
            check_widths($sformatf("req%0d_ehigh", r));
        end

        // Request held from reset: served only after init
        @(posedge clk); #1;
        rst = 1'b1;
        ReadPulse = 1'b1;
        LCD_data = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        n = 0;
        forever begin
            @(negedge clk);
            if (read_done === 1'b1) break;
            n++;
            if (n > 3000) break;
        end
        chk("early_lat", n, INIT_CYC + REQ_LAT);
        ReadPulse = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        exp.delete();
        add_init(exp);
        add_req(exp, 8'h5A);
        check_writes("early_wr", exp);
        chk("early_rd_cnt", rd_cnt, 1);

        // Reset while the character byte is strobed
        @(posedge clk); #1;
        clear_mon();
        LCD_data = 8'($urandom_range(0, 255));
        ReadPulse = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (lcd_e === 1'b1 && lcd_rs === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_found_wr_char", found, 1'b1);
        rst = 1'b1;
        ReadPulse = 1'b0;
        @(negedge clk);
        chk("abort_e", lcd_e, 1'b0);
        chk("abort_busy", busy, 1'b1);
        chk("abort_db", lcd_db, 8'h00);
        chk("abort_rd", read_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rd_cnt", rd_cnt, 0);
        clear_mon();
        wait_idle(n, 3000);
        chk("reinit_len", n, INIT_CYC);
        repeat (3) @(negedge clk);
        #1;
        exp.delete();
        add_init(exp);
        check_writes("reinit_wr", exp);
        chk("reinit_rd_cnt", rd_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
